noise_filter: RTL and testbench

Impulse-noise filter stage that sits directly upstream of the image save stage. It reads an M×N greyscale image from a source RAM, replaces noisy interior pixels with their 8-neighbour mean, and writes every pixel to the output RAM at the same row-major index. It then holds `done` high, which drives the save stage's `saveEn`.

---
 rtl/noise_pkg.sv | 37 +++
 rtl/noise_filter_if.sv | 32 +++
 rtl/noise_decide.sv | 41 ++++
 rtl/noise_filter.sv | 188 ++++++++++++++++++
 tb/tb_noise_filter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noise_pkg.sv
// Shared constants for the impulse-noise filter: FSM encoding,
// 3x3 window offsets and the border classifier.
package noise_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_RD   = 3'd1;
    localparam state_t S_CAP  = 3'd2;
    localparam state_t S_CALC = 3'd3;
    localparam state_t S_WR   = 3'd4;
    localparam state_t S_FIN  = 3'd5;

    localparam int WIN_N = 9;

    localparam int WIN_DR [WIN_N] = '{
        -1, -1, -1, 0, 0, 0, 1, 1, 1
    };
    localparam int WIN_DC [WIN_N] = '{
        -1, 0, 1, -1, 0, 1, -1, 0, 1
    };

    localparam logic [3:0] K_CTR  = 4'd4;
    localparam logic [3:0] K_LAST = 4'd8;

    function automatic logic is_border(
        input logic [15:0] r,
        input logic [15:0] c,
        input logic [15:0] m,
        input logic [15:0] n
    );
        return (m < 16'd3) || (n < 16'd3) ||
               (r == 16'd0) || (r == m - 16'd1) ||
               (c == 16'd0) || (c == n - 16'd1);
    endfunction

endpackage

// File: rtl/noise_filter_if.sv
// Frame control, source-RAM read port and output-RAM write port
// of the noise filter stage.
interface noise_filter_if
    import noise_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  start;
    logic [15:0]           M;
    logic [15:0]           N;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;
    logic                  done;
    logic [31:0]           noise_count;

    modport master (
        output start, M, N, rd_data,
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  busy, done, noise_count
    );

    modport slave (
        input  start, M, N, rd_data,
        output rd_addr, wr_en, wr_addr, wr_data,
        output busy, done, noise_count
    );
endinterface

// File: rtl/noise_decide.sv
// Combinational noise decision for one interior pixel from its
// eight neighbours and centre value.
module noise_decide
    import noise_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int THRESH     = 64
) (
    input  logic [8*DATA_WIDTH-1:0] i_nbrs,
    input  logic [DATA_WIDTH-1:0]   i_centre,
    output logic                    o_noisy,
    output logic [DATA_WIDTH-1:0]   o_pix
);
    localparam int SW = DATA_WIDTH + 3;

    logic [SW-1:0]         w_sum;
    logic [DATA_WIDTH-1:0] w_mean;
    logic [DATA_WIDTH-1:0] w_diff;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum = w_sum +
                SW'(i_nbrs[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    assign w_mean = w_sum[SW-1:3];

    assign w_diff = (i_centre > w_mean) ?
                    i_centre - w_mean :
                    w_mean - i_centre;

    // Stuck-at-black/white pixels are noise regardless of deviation.
    assign o_noisy = (i_centre == '0) ||
                     (i_centre == '1) ||
                     (int'(w_diff) > THRESH);

    assign o_pix = o_noisy ? w_mean : i_centre;

endmodule

// File: rtl/noise_filter.sv
// Impulse-noise filter: walks the frame row-major, reads each pixel's
// window, and writes the filtered pixel at the same index.
module noise_filter
    import noise_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int THRESH     = 64
) (
    input  logic         clk,
    input  logic         rst,
    noise_filter_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic [31:0]   r_cnt;
    logic [15:0]   r_m;
    logic [15:0]   r_n;
    logic [15:0]   r_r;
    logic [15:0]   r_c;
    logic [AW-1:0] r_rb;
    logic [3:0]    r_k;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic [DW-1:0] r_win [WIN_N];

    logic          w_border;
    logic [3:0]    w_ki;
    int            w_dr;
    int            w_dc;
    logic [AW-1:0] w_n;
    logic [AW-1:0] w_row;
    logic [AW-1:0] w_dcv;
    logic [AW-1:0] w_rd_addr;
    logic          w_eol;
    logic          w_last;
    logic [8*DW-1:0] w_nbrs;
    logic          w_noisy;
    logic [DW-1:0] w_pix;

    assign w_border = is_border(r_r, r_c, r_m, r_n);
    assign w_ki     = w_border ? K_CTR : r_k;
    assign w_dr     = WIN_DR[w_ki];
    assign w_dc     = WIN_DC[w_ki];
    assign w_n      = AW'(r_n);

    // Window row base derived from the row-base register, no multiply.
    always_comb begin
        w_row = r_rb;
        unique case (1'b1)
            (w_dr < 0): w_row = r_rb - w_n;
            (w_dr > 0): w_row = r_rb + w_n;
            default:    w_row = r_rb;
        endcase
    end

    always_comb begin
        w_dcv = '0;
        unique case (1'b1)
            (w_dc < 0): w_dcv = '1;
            (w_dc > 0): w_dcv = AW'(1);
            default:    w_dcv = '0;
        endcase
    end

    assign w_rd_addr = w_row + AW'(r_c) + w_dcv;
    assign w_eol     = (r_c == r_n - 16'd1);
    assign w_last    = w_eol && (r_r == r_m - 16'd1);

    assign w_nbrs = {
        r_win[8], r_win[7], r_win[6], r_win[5],
        r_win[3], r_win[2], r_win[1], r_win[0]
    };

    noise_decide #(
        .DATA_WIDTH(DW),
        .THRESH    (THRESH)
    ) u_decide (
        .i_nbrs  (w_nbrs),
        .i_centre(r_win[K_CTR]),
        .o_noisy (w_noisy),
        .o_pix   (w_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            r_m       <= '0;
            r_n       <= '0;
            r_r       <= '0;
            r_c       <= '0;
            r_rb      <= '0;
            r_k       <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            for (int i = 0; i < WIN_N; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE, S_FIN: begin
                    r_state <= S_IDLE;
                    if (bus.start) begin
                        r_m   <= bus.M;
                        r_n   <= bus.N;
                        r_r   <= '0;
                        r_c   <= '0;
                        r_rb  <= '0;
                        r_k   <= '0;
                        r_cnt <= '0;
                        if (bus.M == 16'd0 ||
                            bus.N == 16'd0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_RD;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    // Data for the read issued last cycle.
                    if (r_k != 4'd0) begin
                        r_win[r_k - 4'd1] <= bus.rd_data;
                    end
                    if (w_border || r_k == K_LAST) begin
                        r_state <= S_CAP;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                S_CAP: begin
                    r_win[w_ki] <= bus.rd_data;
                    r_wr_addr   <= r_rb + AW'(r_c);
                    if (w_border) begin
                        r_wr_data <= bus.rd_data;
                        r_state   <= S_WR;
                    end else begin
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_wr_data <= w_pix;
                    if (w_noisy) begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                    r_state <= S_WR;
                end
                S_WR: begin
                    r_k <= '0;
                    if (w_eol) begin
                        r_c  <= '0;
                        r_r  <= r_r + 16'd1;
                        r_rb <= r_rb + w_n;
                    end else begin
                        r_c  <= r_c + 16'd1;
                    end
                    if (w_last) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_RD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_addr     = w_rd_addr;
    assign bus.wr_en       = (r_state == S_WR);
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.noise_count = r_cnt;

endmodule

// File: tb/tb_noise_filter.sv
// Directed self-checking bench for noise_filter with a behavioural
// synchronous source RAM and a write logger.
module tb_noise_filter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noise_filter_if bus ();

    noise_filter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0] src [256];
    always @(posedge clk) bus.rd_data <= src[bus.rd_addr[7:0]];

    int checks = 0;
    int errors = 0;
    int nw;
    int done_cyc;
    int max_busy;
    int la [64];
    int ld [64];
    int lc [64];

    task automatic run_frame(input int m, input int n, input int mid);
        int run;
        run = 0;
        bus.M = 16'(m);
        bus.N = 16'(n);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        nw = 0;
        done_cyc = -1;
        max_busy = 0;
        for (int rel = 1; rel <= 400; rel++) begin
            if (bus.wr_en && nw < 64) begin
                la[nw] = int'(bus.wr_addr);
                ld[nw] = int'(bus.wr_data);
                lc[nw] = rel;
                nw++;
            end
            run = bus.busy ? run + 1 : 0;
            if (run > max_busy) max_busy = run;
            if (bus.done) begin
                done_cyc = rel;
                break;
            end
            bus.start = (rel == mid);
            if (rel == mid) begin
                bus.M = 16'd2;
                bus.N = 16'd2;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.M = 16'(m);
        bus.N = 16'(n);
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL timeout: done not seen within 400 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rd_addr !== 16'd0) begin
            errors++;
            $display("FAIL reset rd_addr: got %0d want 0", bus.rd_addr);
        end
        checks++;
        if (bus.wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset wr_en: got %b want 0", bus.wr_en);
        end
        checks++;
        if (bus.wr_addr !== 16'd0) begin
            errors++;
            $display("FAIL reset wr_addr: got %0d want 0", bus.wr_addr);
        end
        checks++;
        if (bus.wr_data !== 8'd0) begin
            errors++;
            $display("FAIL reset wr_data: got %0d want 0", bus.wr_data);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset busy/done: got %b/%b want 0/0",
                     bus.busy, bus.done);
        end
        checks++;
        if (bus.noise_count !== 32'd0) begin
            errors++;
            $display("FAIL reset noise_count: got %0d want 0",
                     bus.noise_count);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_spike(input int mid);
        for (int i = 0; i < 9; i++) src[i] = 8'd100;
        src[4] = 8'd255;
        run_frame(3, 3, mid);
        checks++;
        if (nw !== 9) begin
            errors++;
            $display("FAIL spike writes: got %0d want 9", nw);
        end
        for (int i = 0; i < nw; i++) begin
            checks++;
            if (la[i] !== i || ld[i] !== 100) begin
                errors++;
                $display("FAIL spike wr[%0d]: got a=%0d d=%0d want a=%0d d=100",
                         i, la[i], ld[i], i);
            end
        end
        checks++;
        if (bus.noise_count !== 32'd1) begin
            errors++;
            $display("FAIL spike count: got %0d want 1", bus.noise_count);
        end
        checks++;
        if (done_cyc !== 37) begin
            errors++;
            $display("FAIL spike done cycle: got %0d want 37", done_cyc);
        end
        checks++;
        if (nw == 0 || lc[nw-1] !== 36) begin
            errors++;
            $display("FAIL spike last write cycle: got %0d want 36",
                     nw == 0 ? -1 : lc[nw-1]);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL spike busy at done: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 16; i++) src[i] = 8'(10 * i);
        run_frame(4, 4, 0);
        checks++;
        if (nw !== 16) begin
            errors++;
            $display("FAIL ramp writes: got %0d want 16", nw);
        end
        for (int i = 0; i < nw; i++) begin
            checks++;
            if (la[i] !== i || ld[i] !== 10 * i) begin
                errors++;
                $display("FAIL ramp wr[%0d]: got a=%0d d=%0d want a=%0d d=%0d",
                         i, la[i], ld[i], i, 10 * i);
            end
        end
        checks++;
        if (bus.noise_count !== 32'd0) begin
            errors++;
            $display("FAIL ramp count: got %0d want 0", bus.noise_count);
        end
        checks++;
        if (done_cyc !== 85) begin
            errors++;
            $display("FAIL ramp done cycle: got %0d want 85", done_cyc);
        end
    endtask

    task automatic test_thresh(input int ctr, input int want_c,
                               input int want_n);
        for (int i = 0; i < 9; i++) src[i] = 8'd100;
        src[4] = 8'(ctr);
        run_frame(3, 3, 0);
        checks++;
        if (nw < 5 || ld[4] !== want_c) begin
            errors++;
            $display("FAIL thresh c=%0d pixel: got %0d want %0d",
                     ctr, nw < 5 ? -1 : ld[4], want_c);
        end
        checks++;
        if (bus.noise_count !== 32'(want_n)) begin
            errors++;
            $display("FAIL thresh c=%0d count: got %0d want %0d",
                     ctr, bus.noise_count, want_n);
        end
    endtask

    task automatic test_empty();
        run_frame(0, 5, 0);
        checks++;
        if (nw !== 0) begin
            errors++;
            $display("FAIL empty writes: got %0d want 0", nw);
        end
        checks++;
        if (done_cyc !== 1) begin
            errors++;
            $display("FAIL empty done cycle: got %0d want 1", done_cyc);
        end
        checks++;
        if (max_busy > 1) begin
            errors++;
            $display("FAIL empty busy run: got %0d want <=1", max_busy);
        end
    endtask

    task automatic test_two_rows();
        logic [7:0] v [8];
        v = '{8'd0, 8'd255, 8'd7, 8'd64, 8'd200, 8'd1, 8'd128, 8'd33};
        for (int i = 0; i < 8; i++) src[i] = v[i];
        run_frame(2, 4, 0);
        checks++;
        if (nw !== 8) begin
            errors++;
            $display("FAIL 2x4 writes: got %0d want 8", nw);
        end
        for (int i = 0; i < nw; i++) begin
            checks++;
            if (la[i] !== i || ld[i] !== int'(v[i]) ||
                lc[i] !== 3 * (i + 1)) begin
                errors++;
                $display("FAIL 2x4 wr[%0d]: got a=%0d d=%0d cyc=%0d want a=%0d d=%0d cyc=%0d",
                         i, la[i], ld[i], lc[i], i, v[i], 3 * (i + 1));
            end
        end
        checks++;
        if (bus.noise_count !== 32'd0 || done_cyc !== 25) begin
            errors++;
            $display("FAIL 2x4 count/done: got %0d/%0d want 0/25",
                     bus.noise_count, done_cyc);
        end
    endtask

    task automatic test_rst_mid();
        int seen;
        for (int i = 0; i < 9; i++) src[i] = 8'd100;
        src[4] = 8'd255;
        bus.M = 16'd3;
        bus.N = 16'd3;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rd_addr !== 16'd0 || bus.wr_en !== 1'b0 ||
            bus.wr_addr !== 16'd0 || bus.wr_data !== 8'd0) begin
            errors++;
            $display("FAIL midrst ram port: got ra=%0d we=%b wa=%0d wd=%0d want 0",
                     bus.rd_addr, bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.noise_count !== 32'd0) begin
            errors++;
            $display("FAIL midrst status: got b=%b d=%b n=%0d want 0",
                     bus.busy, bus.done, bus.noise_count);
        end
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.wr_en || bus.done || bus.busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrst activity after reset: got %0d want 0", seen);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.M = 16'd0;
        bus.N = 16'd0;
        for (int i = 0; i < 256; i++) src[i] = 8'd0;
        test_reset();
        test_spike(0);
        test_ramp();
        test_thresh(164, 164, 0);
        test_thresh(165, 100, 1);
        test_thresh(0, 100, 1);
        test_empty();
        test_two_rows();
        test_spike(10);
        test_rst_mid();
        test_spike(0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
